// File: rtl/sb_serializer.sv
// Sideband transmit serializer: takes a parallel word over valid/ready and shifts it
// out LSB first, one bit per clock under out_clk_en, then holds a fixed idle gap.
module sb_serializer #(
    parameter int WIDTH   = 64,
    parameter int WIDTH_W = 6,
    parameter int GAP     = 32,
    parameter int GAP_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_data_valid,
    output logic             in_data_ready,
    output logic             out_data,
    output logic             out_clk_en
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    // The bit counter is one bit wider than WIDTH_W so it can hold WIDTH itself.
    localparam logic [WIDTH_W:0]  BIT_LAST = (WIDTH_W + 1)'(WIDTH);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP - 1);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   shreg, shreg_nxt;
    logic [WIDTH_W:0]   bit_cnt, bit_cnt_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_nxt;
    logic               out_data_nxt;
    logic               out_clk_en_nxt;
    logic               accept;

    assign in_data_ready = (state == S_IDLE) || ((state == S_GAP) && (gap_cnt == GAP_LAST));
    assign accept        = in_data_valid && in_data_ready;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path through the
        // case leaves one unassigned and no latch is inferred.
        state_nxt      = state;
        shreg_nxt      = shreg;
        bit_cnt_nxt    = bit_cnt;
        gap_cnt_nxt    = gap_cnt;
        out_data_nxt   = out_data;
        out_clk_en_nxt = out_clk_en;

        case (state)
            S_IDLE: begin
                out_data_nxt   = 1'b0;
                out_clk_en_nxt = 1'b0;
            end
            S_SHIFT: begin
                if (bit_cnt == BIT_LAST) begin
                    out_data_nxt   = 1'b0;
                    out_clk_en_nxt = 1'b0;
                    gap_cnt_nxt    = '0;
                    state_nxt      = S_GAP;
                end else begin
                    out_data_nxt = shreg[bit_cnt[WIDTH_W-1:0]];
                    bit_cnt_nxt  = bit_cnt + 1'b1;
                end
            end
            S_GAP: begin
                out_data_nxt   = 1'b0;
                out_clk_en_nxt = 1'b0;
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = S_IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // An accept in the last gap cycle is treated exactly like one from idle.
        if (accept) begin
            shreg_nxt      = in_data;
            out_data_nxt   = in_data[0];
            out_clk_en_nxt = 1'b1;
            bit_cnt_nxt    = (WIDTH_W + 1)'(1);
            state_nxt      = S_SHIFT;
        end
    end

    // NOTE: registered state uses non-blocking assignments only, so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            out_data   <= 1'b0;
            out_clk_en <= 1'b0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            bit_cnt    <= bit_cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
            out_data   <= out_data_nxt;
            out_clk_en <= out_clk_en_nxt;
        end
    end

endmodule

// File: tb/tb_sb_serializer.sv
// Self-checking bench for sb_serializer: a 64/32 lane and an 8/1 lane, each with a
// timing-rule reference model feeding a bit scoreboard checked by a monitor.
module tb_sb_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input int lane, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL lane%0d %s: got 0x%0h, expected 0x%0h", lane, name, act, exp);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int W    = (g == 0) ? 64 : 8;
        localparam int WW   = (g == 0) ? 6  : 3;
        localparam int G    = (g == 0) ? 32 : 1;
        localparam int GW   = (g == 0) ? 6  : 1;
        localparam int RB   = (W > 24) ? 20 : W / 2;
        localparam int NCYC = (g == 0) ? 1500 : 300;

        logic         rst;
        logic [W-1:0] in_data;
        logic         in_data_valid;
        logic         in_data_ready;
        logic         out_data;
        logic         out_clk_en;

        sb_serializer #(
            .WIDTH  (W),
            .WIDTH_W(WW),
            .GAP    (G),
            .GAP_W  (GW)
        ) dut (
            .clk          (clk),
            .rst          (rst),
            .in_data      (in_data),
            .in_data_valid(in_data_valid),
            .in_data_ready(in_data_ready),
            .out_data     (out_data),
            .out_clk_en   (out_clk_en)
        );

        // Model: a word occupies W payload cycles then G idle cycles after its accept edge.
        bit armed  = 1'b0;
        bit active = 1'b0;
        int since  = 0;
        int cyc    = 0;
        int n_acc  = 0;
        int last_acc = 0;
        bit done   = 1'b0;
        bit exp_bits[$];

        task automatic step(input logic r, input logic v, input logic [W-1:0] d);
            logic rdy;
            rst           = r;
            in_data_valid = v;
            in_data       = d;
            rdy           = in_data_ready;
            @(posedge clk);
            cyc++;
            if (r) begin
                armed  = 1'b1;
                active = 1'b0;
                exp_bits.delete();
            end else if (armed) begin
                if (v && rdy === 1'b1) begin
                    for (int k = 0; k < W; k++) exp_bits.push_back(d[k]);
                    active   = 1'b1;
                    since    = 0;
                    n_acc++;
                    last_acc = cyc;
                end else if (active) begin
                    since++;
                end
            end
            @(negedge clk);
        endtask

        task automatic idle(input int n);
            for (int i = 0; i < n; i++) step(1'b0, 1'b0, W'(rand64()));
        endtask

        task automatic send(input logic [W-1:0] d);
            int start;
            int t;
            start = n_acc;
            t     = 0;
            while (n_acc == start && t < 3 * (W + G) + 8) begin
                step(1'b0, 1'b1, d);
                t++;
            end
            check(g, "accept_seen", 64'(n_acc), 64'(start + 1));
        endtask

        always @(negedge clk) begin
            if (armed) begin
                check(g, "clk_en", 64'(out_clk_en), 64'(active && since < W));
                check(g, "ready", 64'(in_data_ready), 64'(!active || since >= W + G - 1));
                if (out_clk_en !== 1'b1)
                    check(g, "idle_data", 64'(out_data), 64'd0);
                else if (exp_bits.size() == 0)
                    check(g, "bits_pending", 64'(exp_bits.size()), 64'd1);
                else
                    check(g, "data_bit", 64'(out_data), 64'(exp_bits.pop_front()));
            end
        end

        initial begin
            logic [W-1:0] w;
            int a1;
            int a2;
            rst           = 1'b1;
            in_data_valid = 1'b0;
            in_data       = '0;
            @(negedge clk);
            step(1'b1, 1'b0, '0);
            step(1'b1, 1'b0, '0);
            idle(3);

            // Single word with only the end bits set.
            w = '0;
            w[0] = 1'b1;
            w[W-1] = 1'b1;
            send(w);
            idle(W + G + 4);

            // Back-to-back alternating words with valid held.
            send({(W / 2){2'b10}});
            a1 = last_acc;
            send({(W / 2){2'b01}});
            a2 = last_acc;
            check(g, "b2b_period", 64'(a2 - a1), 64'(W + G));
            idle(W + G + 4);

            // Valid pulsed mid-word with different data must not disturb the word.
            w = W'(rand64());
            send(w);
            idle(3);
            repeat (4) step(1'b0, 1'b1, ~w);
            idle(W + G + 2);

            // Reset in the middle of a word, then a fresh word afterwards.
            send(W'(rand64()));
            repeat (RB) step(1'b0, 1'b0, W'(rand64()));
            step(1'b1, 1'b1, W'(rand64()));
            step(1'b1, 1'b0, W'(rand64()));
            send(W'(rand64()));
            idle(W + G + 2);

            // 0xC3 twice back-to-back.
            w = '0;
            w[7:0] = 8'hC3;
            send(w);
            a1 = last_acc;
            send(w);
            a2 = last_acc;
            check(g, "c3_period", 64'(a2 - a1), 64'(W + G));
            idle(W + G + 4);

            // Random traffic with occasional resets.
            for (int i = 0; i < NCYC; i++) begin
                step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, W'(rand64()));
            end
            idle(W + G + 4);
            check(g, "drain", 64'(exp_bits.size()), 64'd0);
            done = 1'b1;
        end
    end

    initial begin
        int cycles;
        cycles = 0;
        while (!(lane[0].done && lane[1].done) && cycles < 30000) begin
            @(posedge clk);
            cycles++;
        end
        @(negedge clk);
        check(0, "all_lanes_done", 64'(lane[0].done && lane[1].done), 64'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
